// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups, GPS groups per stage.
// Define ADDER_SAT_EN to clamp the sum on signed overflow (sat reports it); otherwise sat is tied 0.

module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g, p;
   logic [3:1] c;
   logic       gg, pg;

   assign g = a & b;
   assign p = a ^ b;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pg   = &p;
   assign co   = gg | (pg & ci);
   assign s    = p ^ {c, ci};
endmodule

module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GPS   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             sat
);
   localparam int SW      = 4 * GPS;
   localparam int NSTAGES = WIDTH / SW;

   logic               advance;
   logic [NSTAGES-1:0] vld_pipe;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q, ovf_q;
`ifdef ADDER_SAT_EN
   logic               sat_q;
`endif

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_pipe[NSTAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
      end else if (advance) begin
         vld_pipe[0] <= in_valid;
         for (int i = 1; i < NSTAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // Each stage sees only the operand bits it has not consumed yet; finished sum bits ride along below.
   for (genvar s = 0; s < NSTAGES; s++) begin : stg
      localparam int LO = s * SW;
      localparam int HI = LO + SW;

      logic [WIDTH-LO-1:0] a_i, b_i;
      logic                c_i;
      logic [GPS:0]        gc;
      logic [SW-1:0]       gsum;
      logic [HI-1:0]       sum_n;

      if (s == 0) begin : g_in
         assign a_i   = a;
         assign b_i   = sub ? ~b : b;
         assign c_i   = sub | cin;
         assign sum_n = gsum;
      end else begin : g_in
         assign a_i   = stg[s-1].g_mid.a_q;
         assign b_i   = stg[s-1].g_mid.b_q;
         assign c_i   = stg[s-1].g_mid.c_q;
         assign sum_n = {gsum, stg[s-1].g_mid.sum_q};
      end

      assign gc[0] = c_i;
      for (genvar j = 0; j < GPS; j++) begin : grp
         cla_group4 u_grp (
            .a  (a_i[4*j +: 4]),
            .b  (b_i[4*j +: 4]),
            .ci (gc[j]),
            .s  (gsum[4*j +: 4]),
            .co (gc[j+1])
         );
      end

      if (s < NSTAGES-1) begin : g_mid
         logic [WIDTH-HI-1:0] a_q, b_q;
         logic [HI-1:0]       sum_q;
         logic                c_q;

         always_ff @(posedge clk) begin
            if (advance) begin
               a_q   <= a_i[WIDTH-LO-1:SW];
               b_q   <= b_i[WIDTH-LO-1:SW];
               sum_q <= sum_n;
               c_q   <= gc[GPS];
            end
         end
      end else begin : g_out
         logic             ovf_n;
         logic [WIDTH-1:0] res_n;

         // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
         assign ovf_n = a_i[SW-1] ^ b_i[SW-1] ^ gsum[SW-1] ^ gc[GPS];
`ifdef ADDER_SAT_EN
         logic sat_n;
         always_comb begin
            res_n = sum_n;
            sat_n = ovf_n;
            if (ovf_n)
               res_n = a_i[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end
`else
         assign res_n = sum_n;
`endif

         always_ff @(posedge clk) begin
            if (reset) begin
               sum_q  <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
`ifdef ADDER_SAT_EN
               sat_q  <= 1'b0;
`endif
            end else if (advance) begin
               sum_q  <= res_n;
               cout_q <= gc[GPS];
               ovf_q  <= ovf_n;
`ifdef ADDER_SAT_EN
               sat_q  <= sat_n;
`endif
            end
         end
      end
   end

   // Bubble data never leaks out: result fields read zero whenever out_valid is low.
   assign sum  = out_valid ? sum_q : '0;
   assign cout = out_valid & cout_q;
   assign ovf  = out_valid & ovf_q;
`ifdef ADDER_SAT_EN
   assign sat  = out_valid & sat_q;
`else
   assign sat  = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, GPS=1): directed corners plus a randomized
// backpressured stream checked against an arithmetic reference model.

module tb_pipelined_cla_adder;
   localparam int WIDTH = 16;

   typedef struct {
      logic [15:0] sum;
      logic        cout, ovf, sat;
   } res_t;

   logic             clk = 1'b0;
   logic             reset, in_valid, in_ready, cin, sub;
   logic             out_valid, out_ready, cout, ovf, sat;
   logic [WIDTH-1:0] a, b, sum;

   res_t exp_q[$];
   int   n_chk = 0, n_pass = 0, n_got = 0;
   logic held = 1'b0;
   res_t held_r;

   pipelined_cla_adder #(.WIDTH(WIDTH), .GPS(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
   endtask

   // Signed/unsigned arithmetic on plain integers; no carry chains.
   function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, input logic sb);
      res_t r;
      int   sx = $signed(x);
      int   sy = $signed(y);
      int   ux = x;
      int   uy = y;
      int   c  = ci;
      int   ex;
      ex     = sb ? (sx - sy) : (sx + sy + c);
      r.cout = sb ? (ux >= uy) : ((ux + uy + c) > 65535);
      r.ovf  = (ex > 32767) || (ex < -32768);
      r.sum  = ex[15:0];
      r.sat  = 1'b0;
`ifdef ADDER_SAT_EN
      if (r.ovf) begin
         r.sum = (ex > 0) ? 16'h7FFF : 16'h8000;
         r.sat = 1'b1;
      end
`endif
      return r;
   endfunction

   task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input logic sb, input logic [15:0] e_sum,
                           input logic e_cout, input logic e_ovf, input logic e_sat);
      in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_early"}, out_valid, 0);
         step();
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_sum"},   sum,       e_sum);
      chk({tag, "_cout"},  cout,      e_cout);
      chk({tag, "_ovf"},   ovf,       e_ovf);
      chk({tag, "_sat"},   sat,       e_sat);
      step();
   endtask

   task automatic drive_cycle(input logic iv, input logic [15:0] x, input logic [15:0] y,
                              input logic ci, input logic sb, input logic ordy,
                              output logic acc);
      res_t r;
      in_valid = iv; a = x; b = y; cin = ci; sub = sb; out_ready = ordy;
      #1;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (held) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_sum",   sum,       held_r.sum);
         chk("hold_cout",  cout,      held_r.cout);
         chk("hold_ovf",   ovf,       held_r.ovf);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious", out_valid, 0);
         end else begin
            r = exp_q.pop_front();
            n_got++;
            chk("rnd_sum",  sum,  r.sum);
            chk("rnd_cout", cout, r.cout);
            chk("rnd_ovf",  ovf,  r.ovf);
            chk("rnd_sat",  sat,  r.sat);
         end
      end
      held   = out_valid && !out_ready;
      held_r = '{sum, cout, ovf, sat};
      acc    = iv && in_ready;
      if (acc) exp_q.push_back(model(x, y, ci, sb));
      step();
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rc, rs, acc;
      int          sent;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_sum",       sum,       0);
      chk("rst_cout",      cout,      0);
      chk("rst_ovf",       ovf,       0);
      chk("rst_sat",       sat,       0);

      directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef ADDER_SAT_EN
      directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
`else
      directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`endif
      directed("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef ADDER_SAT_EN
      directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1);
`else
      directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
      directed("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);

      // Randomized stream under out_ready pattern 1,0,0,1,0,0,...
      sent = 0; n_got = 0;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
      for (int cyc = 0; cyc < 80 && n_got < 8; cyc++) begin
         drive_cycle(sent < 8, ra, rb, rc, rs, (cyc % 3) == 0, acc);
         if (acc) begin
            sent++;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
         end
      end
      chk("stream_count", n_got, 8);
      chk("stream_drained", exp_q.size(), 0);

      // Fill the pipe, then reset mid-flight.
      for (int i = 0; i < 4; i++)
         drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, acc);
      chk("full_valid", out_valid, 1);
      chk("full_stall", in_ready,  0);
      reset = 1'b1; in_valid = 1'b0;
      step();
      reset = 1'b0;
      chk("flush_valid", out_valid, 0);
      exp_q.delete();
      held = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("no_stale", out_valid, 0);
         drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
      end
      directed("post_rst", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's fixed 4-bit ripple and lookahead adders.
- WIDTH is split into 4-bit lookahead groups. Groups are registered in pipeline stages; carry passes between stages through a register.
- Valid/ready handshake on both sides, full backpressure, one result per cycle. Feeds the datapath ALU and accumulator blocks.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4.
- GPS, 1, 4-bit groups evaluated per pipeline stage; (WIDTH/4) must be divisible by GPS.
- NSTAGES (localparam), WIDTH/(4*GPS), pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB (0 means borrow in subtract mode)
- ovf  out  1  signed two's-complement overflow
- sat  out  1  result was saturated (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0; sat = 0. in_ready = 1 in the first cycle after reset.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Stall rule: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance = 1, all stages shift one position together; stage 0 loads the input and its valid bit = in_valid.
  - When advance = 0, all stage registers hold, so sum/cout/ovf/sat stay stable while out_valid is high.
- Latency: a transfer accepted at edge k produces out_valid = 1 after edge k+NSTAGES-1 (NSTAGES cycles in total), provided there are no stalls. Throughput is 1 result per cycle. Results leave in order; none is dropped or duplicated.
- Operand preparation (stage 0): b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Group logic within a stage:
  - For each 4-bit group: g = a&b_eff, p = a^b_eff.
  - Carries: c[i+1] = g[i] | p[i]&c[i], flattened to lookahead form inside the group.
  - Group carry-out = G | P&cin_group.
  - With GPS > 1, group carries ripple combinationally within the stage.
- Stage s computes groups s*GPS .. s*GPS+GPS-1.
  - Upper operand bits travel forward in skew registers.
  - Sum bits already computed travel forward in aligned registers.
  - The inter-stage carry is registered together with its data.
- Final stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Bubbles: invalid stages still shift on advance. Data in invalid stages is don't-care and must never reach the outputs while out_valid = 0.
- Reset during operation: all in-flight entries are discarded on the reset edge and out_valid = 0 in the next cycle.
- Simultaneous out transfer and in transfer in the same cycle is legal and keeps the pipeline full.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined: on ovf = 1, sum is clamped.
  - If the MSB of a equals the MSB of b_eff and is 0, sum = 0x7F..F.
  - If that shared MSB is 1, sum = 0x80..0.
  - sat = 1 for that result. cout and ovf report the raw, unclamped values.
  - Clamping happens in the final stage and adds no latency.
- Not defined: sum wraps modulo 2^WIDTH; the sat port exists and is tied to 0.

Test Plan (WIDTH=16, GPS=1, NSTAGES=4):
- Reset held for 2 cycles, then released → out_valid=0, in_ready=1, sum=0x0000, cout=0, ovf=0, sat=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0, single transfer → after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, add → sum=0x8000, ovf=1, sat=0. With ADDER_SAT_EN: sum=0x7FFF, sat=1, ovf=1.
- a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1 (0x8000 with ADDER_SAT_EN).
- 8 back-to-back transfers with random operands while out_ready toggles 1,0,0,1,... → all 8 results appear in order and match the model; outputs are stable during stalls; in_ready=0 exactly when out_valid && !out_ready.
- Pipeline full (4 entries in flight), reset asserted for 1 cycle → out_valid=0 in the next cycle; no stale result ever appears afterwards.
